// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master constants, frame geometry and state type
// Purpose: frame field widths, read/write flag values and the master FSM states.
// Ports: none (package).
package spi_pkg;
  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 8;
  localparam int FRAME_BITS = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2,
    GAP   = 2'd3
  } state_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider with tick, rise and fall strobes
// Purpose: counts CLK_DIV clk cycles per SCLK half-period while run is high.
// Ports: clk, reset_n (sync, active-low), run (count enable, clears when low),
//        toggle_en (allow SCLK to toggle on a tick), tick (half-period boundary),
//        rise/fall (tick that drives SCLK high/low), sclk (registered SCLK level).
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic toggle_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Strobes are combinational so the top can update its registered pins on
  // the very clk edge where SCLK changes.
  assign tick = run && (cnt == LAST);
  assign rise = tick && toggle_en && !sclk;
  assign fall = tick && toggle_en && sclk;

  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick && toggle_en) begin
        sclk <= !sclk;
      end
    end
  end
endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master issuing 16-bit {addr, rw, wdata} frames
// Purpose: serialises one register access per start, captures read data.
// Ports: clk, reset_n (sync, active-low), start/rw/addr/wdata (request),
//        rdata/busy/done (status), sclk_pin/cs_pin/mosi_pin/miso_pin (SPI bus).
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk_pin,
  output logic                  cs_pin,
  output logic                  mosi_pin,
  input  logic                  miso_pin
);
  localparam logic [5:0] LAST_EDGE = 6'(2 * FRAME_BITS - 1);

  state_t                state, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [5:0]            edge_q, edge_d;
  logic                  rd_q, rd_d;
  logic                  cs_d, mosi_d, busy_d, done_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  tick, rise, fall;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (state != IDLE),
    .toggle_en (state == SHIFT),
    .tick      (tick),
    .rise      (rise),
    .fall      (fall),
    .sclk      (sclk_pin)
  );

  always_comb begin
    state_d = state;
    tx_d    = tx_q;
    rx_d    = rx_q;
    edge_d  = edge_q;
    rd_d    = rd_q;
    cs_d    = cs_pin;
    mosi_d  = mosi_pin;
    busy_d  = busy;
    done_d  = 1'b0;
    rdata_d = rdata;
    case (state)
      IDLE: begin
        if (start) begin
          tx_d    = {addr, rw, wdata};
          rd_d    = (rw == RW_READ);
          cs_d    = 1'b0;
          mosi_d  = addr[ADDR_WIDTH-1];
          busy_d  = 1'b1;
          edge_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          edge_d = edge_q + 6'd1;
        end
        // LSB-in: after 16 rises the register holds the bits from rises 9..16.
        if (rise) begin
          rx_d = {rx_q[DATA_WIDTH-2:0], miso_pin};
        end
        if (tick && edge_q == LAST_EDGE) begin
          mosi_d  = 1'b0;
          edge_d  = '0;
          state_d = TAIL;
        end else if (fall) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_q[FRAME_BITS-2];
        end
      end
      TAIL: begin
        if (tick) begin
          cs_d    = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (rd_q) begin
            rdata_d = rx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      edge_q   <= '0;
      rd_q     <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      edge_q   <= edge_d;
      rd_q     <= rd_d;
      cs_pin   <= cs_d;
      mosi_pin <= mosi_d;
      busy     <= busy_d;
      done     <= done_d;
      rdata    <= rdata_d;
    end
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL take parameter CLK_DIV, default 4; clk cycles per SCLK half-period; minimum legal value 1.
REQ-002 SHALL have port clk, input, 1 bit; single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit; transaction request, sampled only in IDLE.
REQ-005 SHALL have port rw, input, 1 bit; 1 = read, 0 = write; sent as frame bit 8.
REQ-006 SHALL have port addr, input, 7 bits; register address; sent MSB first as frame bits 15..9.
REQ-007 SHALL have port wdata, input, 8 bits; write data; sent MSB first as frame bits 7..0.
REQ-008 SHALL have port rdata, output, 8 bits; last read result, registered.
REQ-009 SHALL have port busy, output, 1 bit; high while a transaction is in progress.
REQ-010 SHALL have port done, output, 1 bit; one-cycle completion pulse.
REQ-011 SHALL have port sclk_pin, output, 1 bit; serial clock; idles low (mode 0).
REQ-012 SHALL have port cs_pin, output, 1 bit; active-low chip select.
REQ-013 SHALL have port mosi_pin, output, 1 bit; serial data to the memory.
REQ-014 SHALL have port miso_pin, input, 1 bit; serial data from the memory.

Function
REQ-015 SHALL implement states IDLE, SHIFT, TAIL and GAP; every output SHALL be registered.
REQ-016 IDLE with start=1: at the accepting edge t0, latch frame {addr, rw, wdata} into a 16-bit shift register, drive cs_pin=0, mosi_pin=frame[15], sclk_pin=0 and busy=1, reset the divider counter, then enter SHIFT.
REQ-017 SHIFT: toggle sclk_pin every CLK_DIV clk cycles, giving edges at t0+k*CLK_DIV for k=1..32 (16 SCLK pulses).
REQ-018 Rising SCLK edges (k odd): at the same clk edge that drives sclk_pin high, sample miso_pin into the receive shift register, LSB-in.
REQ-019 Falling SCLK edges (k even, k<32): present the next frame bit on mosi_pin, MSB first.
REQ-020 At k=32: drive mosi_pin=0 and enter TAIL.
REQ-021 TAIL: hold cs_pin=0 for CLK_DIV cycles, then drive cs_pin=1 and enter GAP.
REQ-022 GAP: hold cs_pin=1 for CLK_DIV cycles, then enter IDLE with done=1 and busy=0 in the same cycle; done is high exactly 34*CLK_DIV edges after t0.
REQ-023 Read (rw=1): load rdata from the receive bits sampled on SCLK rises 9..16 when entering IDLE.
REQ-024 Write (rw=0): leave rdata unchanged.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 start held high continuously SHALL begin the next transaction on the first IDLE cycle after done.
REQ-027 CS high time between frames SHALL be at least CLK_DIV+1 cycles.
REQ-028 addr, rw and wdata changes after t0 SHALL NOT affect the frame in flight.
REQ-029 miso_pin is sampled without a synchronizer; the memory shares clk.

Reset
REQ-030 reset_n=0 at a clk edge SHALL force, at that edge: state=IDLE, cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=8'h00, and both counter and shift registers to 0.
REQ-031 Reset mid-transaction SHALL abort without a done pulse; start is ignored while reset_n=0.

Structure
REQ-032 Shared package spi_pkg SHALL hold ADDR_WIDTH=7, DATA_WIDTH=8, FRAME_BITS=16, the state enum, and the RW_READ=1/RW_WRITE=0 constants.
REQ-033 SHALL contain one sub-module, spi_sclk_gen (divider counter with rise/fall strobes and SCLK level, parameter CLK_DIV); the counter SHALL be clog2(CLK_DIV)+1 bits wide.

Verification (CLK_DIV=4)
REQ-034 Write: addr=7'h1D, rw=0, wdata=8'hAA -> mosi_pin captured on 16 SCLK rises = 16'h3AAA; cs_pin low for 33*4 cycles; done at t0+136; rdata unchanged.
REQ-035 Read: addr=7'h1D, rw=1, memory model drives 8'hAA on MISO bits 9..16 (changing on SCLK falls) -> mosi_pin header 8'h3B, rdata=8'hAA at done.
REQ-036 Busy rejection: second start pulse at t0+40 with a different addr -> no effect; exactly one frame and one done.
REQ-037 Back-to-back: start held high for two frames -> second cs_pin fall occurs exactly 1 cycle after done; cs_pin high for 5 cycles.
REQ-038 Reset abort: reset_n low at t0+50 for 1 cycle -> next edge cs_pin=1, sclk_pin=0, busy=0, done never pulses, rdata=8'h00.
REQ-039 CLK_DIV=1 build: write 16'h3AAA frame -> SCLK period of 2 cycles; done at t0+34.
